// File: rtl/project_select_pkg.sv
// rtl/project_select_pkg.sv - register map, field positions, FSM states and helpers for project_select_ctrl
package project_select_pkg;

    // Width of the drain guard register and counter
    localparam int GUARD_W = 16;

    // Register byte offsets inside the 16-byte window
    localparam logic [3:0] REG_SEL    = 4'h0;
    localparam logic [3:0] REG_GUARD  = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_COUNT  = 4'hC;

    // Field bit positions
    localparam int IDX_W          = 5;
    localparam int SEL_IDX_LSB    = 0;
    localparam int SEL_EN_BIT     = 8;
    localparam int ST_BUSY_BIT    = 9;
    localparam int ST_STATE_LSB   = 16;
    localparam int ST_DONE_BIT    = 31;
    localparam int COUNT_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    // Merge a write into an existing word, one byte lane at a time
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Project enable vector for a given selection; all-zero when disabled
    function automatic logic [31:0] onehot_of(input logic en, input logic [IDX_W-1:0] idx);
        logic [31:0] r;
        r = 32'd0;
        if (en) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/project_select_ctrl_if.sv
// rtl/project_select_ctrl_if.sv - Wishbone slave bus bundle for project_select_ctrl
interface project_select_ctrl_if (input logic clk);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;

    modport master (input clk, output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
    modport slave  (input clk, input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/project_select_ctrl.sv
// rtl/project_select_ctrl.sv - Wishbone-controlled one-hot project selector with drain guard
module project_select_ctrl
    import project_select_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          GUARD_DEFAULT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] active,
    output logic        irq_o
);

    // Bus-side registers
    logic             ack_q;
    logic             we_q;
    logic [1:0]       word_q;
    logic [31:0]      wdat_q;
    logic [3:0]       wsel_q;
    logic [31:0]      rdat_q;

    // Control/state registers
    state_e           state_q;
    logic             cur_en_q;
    logic [IDX_W-1:0] cur_idx_q;
    logic             pend_en_q;
    logic [IDX_W-1:0] pend_idx_q;
    logic [GUARD_W-1:0] guard_q;
    logic [GUARD_W-1:0] cnt_q;
    logic [COUNT_W-1:0] count_q;
    logic             done_q;
    logic [31:0]      active_q;

    // Decode; a request is not re-accepted while its ack is showing
    logic req;
    assign req = wbs_cyc_i & wbs_stb_i & ~ack_q & ~wb_rst_i &
                 (wbs_adr_i[31:4] == BASE_ADDR[31:4]);

    // Low address bits are byte offsets within a word and carry no meaning here
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];

    // Register views
    logic [31:0] sel_view;
    logic [31:0] guard_view;
    logic [31:0] status_view;
    logic [31:0] count_view;
    logic        busy;

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        sel_view                  = 32'd0;
        sel_view[SEL_EN_BIT]      = pend_en_q;
        sel_view[SEL_IDX_LSB +: IDX_W] = pend_idx_q;

        guard_view                = 32'd0;
        guard_view[GUARD_W-1:0]   = guard_q;

        status_view                         = 32'd0;
        status_view[SEL_IDX_LSB +: IDX_W]   = cur_idx_q;
        status_view[SEL_EN_BIT]             = cur_en_q;
        status_view[ST_BUSY_BIT]            = busy;
        status_view[ST_STATE_LSB +: 2]      = state_q;
        status_view[ST_DONE_BIT]            = done_q;

        count_view                = 32'd0;
        count_view[COUNT_W-1:0]   = count_q;
    end

    // Read data selected by the incoming address
    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = 32'd0;
        case (wbs_adr_i[3:2])
            REG_SEL[3:2]:    rd_mux = sel_view;
            REG_GUARD[3:2]:  rd_mux = guard_view;
            REG_STATUS[3:2]: rd_mux = status_view;
            REG_COUNT[3:2]:  rd_mux = count_view;
            default:         rd_mux = 32'd0;
        endcase
    end

    // Writes commit on the ack cycle using the captured request
    logic wr_sel;
    logic wr_guard;
    logic wr_status;
    assign wr_sel    = ack_q & we_q & (word_q == REG_SEL[3:2]);
    assign wr_guard  = ack_q & we_q & (word_q == REG_GUARD[3:2]);
    assign wr_status = ack_q & we_q & (word_q == REG_STATUS[3:2]);

    logic [31:0]        sel_merged;
    logic [31:0]        guard_merged;
    logic               new_en;
    logic [IDX_W-1:0]   new_idx;
    logic [GUARD_W-1:0] guard_load;
    logic               done_clr;

    assign sel_merged   = byte_merge(sel_view, wdat_q, wsel_q);
    assign guard_merged = byte_merge(guard_view, wdat_q, wsel_q);
    assign new_en       = sel_merged[SEL_EN_BIT];
    assign new_idx      = sel_merged[SEL_IDX_LSB +: IDX_W];
    // A guard of zero still drains for one cycle
    assign guard_load   = (guard_q == '0) ? GUARD_W'(1) : guard_q;
    assign done_clr     = wr_status & wsel_q[3] & wdat_q[ST_DONE_BIT];

    // Upper bits of the merged words feed no register
    logic unused_merge;
    assign unused_merge = ^{sel_merged[31:9], sel_merged[7:5], guard_merged[31:GUARD_W]};

    // Latest pending value including a write committing this cycle
    logic             pend_en_eff;
    logic [IDX_W-1:0] pend_idx_eff;
    assign pend_en_eff  = wr_sel ? new_en  : pend_en_q;
    assign pend_idx_eff = wr_sel ? new_idx : pend_idx_q;

    logic sel_differs;
    assign sel_differs = ({new_en, new_idx} != {cur_en_q, cur_idx_q});

    // Wishbone slave: single-cycle ack with registered read data
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            we_q   <= 1'b0;
            word_q <= 2'd0;
            wdat_q <= 32'd0;
            wsel_q <= 4'd0;
            rdat_q <= 32'd0;
        end else begin
            ack_q <= req;
            if (req) begin
                we_q   <= wbs_we_i;
                word_q <= wbs_adr_i[3:2];
                wdat_q <= wbs_dat_i;
                wsel_q <= wbs_sel_i;
                rdat_q <= wbs_we_i ? 32'd0 : rd_mux;
            end else begin
                we_q   <= 1'b0;
                rdat_q <= 32'd0;
            end
        end
    end

    // Switch FSM: drain with active cleared, then apply the pending selection
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            cur_en_q   <= 1'b0;
            cur_idx_q  <= '0;
            pend_en_q  <= 1'b0;
            pend_idx_q <= '0;
            guard_q    <= GUARD_W'(GUARD_DEFAULT);
            cnt_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            active_q   <= 32'd0;
        end else begin
            if (wr_guard) begin
                guard_q <= guard_merged[GUARD_W-1:0];
            end
            if (done_clr) begin
                done_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (wr_sel) begin
                        pend_en_q  <= new_en;
                        pend_idx_q <= new_idx;
                        if (sel_differs) begin
                            state_q  <= ST_DRAIN;
                            active_q <= 32'd0;
                            cnt_q    <= guard_load;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wr_sel) begin
                        pend_en_q  <= new_en;
                        pend_idx_q <= new_idx;
                    end
                    if (cnt_q <= GUARD_W'(1)) begin
                        state_q   <= ST_APPLY;
                        active_q  <= onehot_of(pend_en_eff, pend_idx_eff);
                        cur_en_q  <= pend_en_eff;
                        cur_idx_q <= pend_idx_eff;
                    end else begin
                        cnt_q <= cnt_q - GUARD_W'(1);
                    end
                end
                ST_APPLY: begin
                    count_q <= count_q + COUNT_W'(1);
                    done_q  <= 1'b1;
                    if (wr_sel) begin
                        pend_en_q  <= new_en;
                        pend_idx_q <= new_idx;
                    end
                    if (wr_sel && sel_differs) begin
                        state_q  <= ST_DRAIN;
                        active_q <= 32'd0;
                        cnt_q    <= guard_load;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    active_q <= 32'd0;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign active    = active_q;
    assign irq_o     = done_q;

endmodule
